// File: rtl/lag_window_pkg.sv
// Shared constants, state encoding and fractional-arithmetic primitives for the LPC chain.
// Latency: n/a (package: constants and combinational helper functions only).
// Backpressure: n/a.
package lag_window_pkg;

    localparam int M = 10;

    // Scratch-memory map shared with the autocorrelation and Levinson stages (16-word aligned).
    localparam logic [11:0] AUTOCORR_R   = 12'h100;
    localparam logic [11:0] LAG_WINDOW_R = 12'h140;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        CALC,
        WRITE,
        FIN
    } lagState_t;

    // Lag-window coefficients as hi/lo double-precision pairs, indexed by lag-1.
    localparam logic [15:0] LAG_H [M] = '{
        16'd32728, 16'd32619, 16'd32438, 16'd32187, 16'd31867,
        16'd31480, 16'd31029, 16'd30517, 16'd29946, 16'd29321
    };
    localparam logic [15:0] LAG_L [M] = '{
        16'd11904, 16'd17280, 16'd30720, 16'd25856, 16'd24192,
        16'd28992, 16'd24384, 16'd7360,  16'd19520, 16'd14784
    };

    // Saturating 32-bit add.
    function automatic logic signed [31:0] lAdd(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [32:0] s;
        s = 33'(a) + 33'(b);
        if (s[32] != s[31]) begin
            return s[32] ? 32'sh80000000 : 32'sh7FFFFFFF;
        end
        return s[31:0];
    endfunction

    // sat(2*a*b); only -32768 * -32768 can overflow.
    function automatic logic signed [31:0] lMult(input logic signed [15:0] a, input logic signed [15:0] b);
        logic signed [31:0] p;
        p = 32'(a) * 32'(b);
        if (p == 32'sh40000000) begin
            return 32'sh7FFFFFFF;
        end
        return p <<< 1;
    endfunction

    // acc + L_mult(a, b), saturating.
    function automatic logic signed [31:0] lMac(input logic signed [31:0] acc, input logic signed [15:0] a,
                                                input logic signed [15:0] b);
        return lAdd(acc, lMult(a, b));
    endfunction

    // sat((a*b) >> 15) to the 16-bit range.
    function automatic logic signed [15:0] mult(input logic signed [15:0] a, input logic signed [15:0] b);
        logic signed [31:0] q;
        q = (32'(a) * 32'(b)) >>> 15;
        if (q > 32'sd32767) begin
            return 16'sh7FFF;
        end
        if (q < -32'sd32768) begin
            return 16'sh8000;
        end
        return q[15:0];
    endfunction

endpackage

// File: rtl/lag_window_mpy_32.sv
// Double-precision fractional multiply: 32-bit value times a hi/lo 16-bit coefficient pair.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module mpy_32
    import lag_window_pkg::*;
(
    input  logic [31:0] lIn,
    input  logic [15:0] coefH,
    input  logic [15:0] coefL,
    output logic [31:0] result
);

    logic signed [31:0] lS;
    logic signed [31:0] half;
    logic signed [15:0] hi;
    logic signed [15:0] lo;
    logic signed [15:0] cH;
    logic signed [15:0] cL;
    logic signed [31:0] acc0;
    logic signed [31:0] acc1;
    logic signed [31:0] acc2;

    // Split the input into hi/lo halves, then hi*cH + hi*cL + lo*cH with saturation at every step.
    always_comb begin
        lS     = lIn;
        cH     = coefH;
        cL     = coefL;
        hi     = lS[31:16];
        half   = lS >>> 1;
        lo     = 16'(half - (32'(hi) <<< 15));
        acc0   = lMult(hi, cH);
        acc1   = lMac(acc0, mult(hi, cL), 16'sd1);
        acc2   = lMac(acc1, mult(lo, cH), 16'sd1);
        result = acc2;
    end

endmodule

// File: rtl/lag_window.sv
// Applies the lag window to r[1..M] in scratch memory, copying r[0]; output feeds Levinson-Durbin.
// Latency: 4 cycles per word (read, latch, calc, write), done one FIN cycle after the last write.
// Backpressure: none; start is taken only in IDLE, the registered RAM is assumed always ready.
module lag_window
    import lag_window_pkg::*;
#(
    parameter logic [11:0] R_IN_BASE  = AUTOCORR_R,
    parameter logic [11:0] R_OUT_BASE = LAG_WINDOW_R
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] memOut,
    output logic [11:0] memReadAddr,
    output logic [11:0] memWriteAddr,
    output logic [31:0] memIn,
    output logic        memWrite,
    output logic        done
);

    localparam logic [3:0] LAST = 4'(M);

    lagState_t   state;
    lagState_t   nextState;
    logic [3:0]  i;
    logic [31:0] rReg;
    logic [3:0]  lagIdx;
    logic [15:0] coefH;
    logic [15:0] coefL;
    logic [31:0] mpyRes;

    // Coefficient lookup; index 0 is a don't-care because r[0] bypasses the multiplier.
    always_comb begin
        lagIdx = (i == 4'd0) ? 4'd0 : i - 4'd1;
        coefH  = LAG_H[lagIdx];
        coefL  = LAG_L[lagIdx];
    end

    mpy_32 u_mpy (
        .lIn    (rReg),
        .coefH  (coefH),
        .coefL  (coefL),
        .result (mpyRes)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: one pass of M+1 words, then a single FIN cycle that ignores start.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = READ;
            READ:    nextState = LATCH;
            LATCH:   nextState = CALC;
            CALC:    nextState = WRITE;
            WRITE:   nextState = (i == LAST) ? FIN : READ;
            FIN:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Index, address generation and datapath registers; the read address is set up ahead of READ.
    always_ff @(posedge clk) begin
        if (reset) begin
            i            <= 4'd0;
            rReg         <= 32'd0;
            memReadAddr  <= 12'd0;
            memWriteAddr <= 12'd0;
            memIn        <= 32'd0;
            memWrite     <= 1'b0;
            done         <= 1'b0;
        end else begin
            memWrite <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        i           <= 4'd0;
                        done        <= 1'b0;
                        memReadAddr <= R_IN_BASE;
                    end
                end
                LATCH: rReg <= memOut;
                CALC: begin
                    memWrite     <= 1'b1;
                    memWriteAddr <= R_OUT_BASE + {8'd0, i};
                    memIn        <= (i == 4'd0) ? rReg : {mpyRes[31:1], 1'b0};
                end
                WRITE: begin
                    if (i != LAST) begin
                        i           <= i + 4'd1;
                        memReadAddr <= R_IN_BASE + {8'd0, i + 4'd1};
                    end
                end
                FIN: done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lag_window.sv
// Self-checking bench for lag_window: registered-RAM read model, write scoreboard, control checks.
// Latency: expects done 45 edges after the start-sampling edge (44 word cycles plus FIN).
// Backpressure: none exercised; start pulses mid-pass and in FIN must be ignored.
module tb_lag_window;

    localparam logic [11:0] IN_BASE  = 12'h100;
    localparam logic [11:0] OUT_BASE = 12'h140;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] memOut;
    logic [11:0] memReadAddr;
    logic [11:0] memWriteAddr;
    logic [31:0] memIn;
    logic        memWrite;
    logic        done;

    logic [31:0] rIn [11];
    logic [11:0] expAddr [$];
    logic [31:0] expDat [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          writeCnt = 0;

    int lagH [10] = '{32728, 32619, 32438, 32187, 31867, 31480, 31029, 30517, 29946, 29321};
    int lagL [10] = '{11904, 17280, 30720, 25856, 24192, 28992, 24384, 7360, 19520, 14784};

    lag_window #(
        .R_IN_BASE  (IN_BASE),
        .R_OUT_BASE (OUT_BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .memOut       (memOut),
        .memReadAddr  (memReadAddr),
        .memWriteAddr (memWriteAddr),
        .memIn        (memIn),
        .memWrite     (memWrite),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint sat32(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic longint sat16(input longint v);
        if (v > 64'sd32767) return 64'sd32767;
        if (v < -64'sd32768) return -64'sd32768;
        return v;
    endfunction

    // Reference lag-window word computed with wide integer arithmetic.
    function automatic logic [31:0] lagRef(input logic [31:0] r, input int k);
        longint lv, hi, lo, acc;
        if (k == 0) return r;
        lv  = longint'($signed(r));
        hi  = lv >>> 16;
        lo  = (lv >>> 1) - hi * 32768;
        acc = sat32(2 * hi * lagH[k-1]);
        acc = sat32(acc + 2 * sat16((hi * lagL[k-1]) >>> 15));
        acc = sat32(acc + 2 * sat16((lo * lagH[k-1]) >>> 15));
        return 32'(acc) & 32'hFFFFFFFE;
    endfunction

    // Registered RAM read port; addresses outside r[0..10] return a marker value.
    always @(posedge clk) begin
        if (memReadAddr >= IN_BASE && memReadAddr <= IN_BASE + 12'd10) begin
            memOut <= rIn[int'(memReadAddr - IN_BASE)];
        end else begin
            memOut <= 32'hDEADBEEF;
        end
    end

    // Write monitor: every strobe is checked against the next scoreboard entry.
    always @(negedge clk) begin
        if (memWrite) begin
            writeCnt++;
            if (expAddr.size() == 0) begin
                checkVal("spuriousWr", 32'(expAddr.size()), 32'd1);
            end else begin
                checkVal("wrAddr", 32'(memWriteAddr), 32'(expAddr.pop_front()));
                checkVal("wrData", memIn, expDat.pop_front());
            end
        end
    end

    task automatic pushExpected();
        for (int k = 0; k < 11; k++) begin
            expAddr.push_back(OUT_BASE + 12'(k));
            expDat.push_back(lagRef(rIn[k], k));
        end
    endtask

    // One full pass; glitchAt >= 0 pulses start for one cycle that many edges into the pass.
    task automatic runPass(input int glitchAt);
        int n;
        pushExpected();
        writeCnt = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checkVal("doneClr", 32'(done), 32'd0);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            start = (n == glitchAt);
        end
        start = 1'b0;
        checkVal("doneLat", 32'(n), 32'd45);
        checkVal("wrCnt", 32'(writeCnt), 32'd11);
        checkVal("sbEmpty", 32'(expAddr.size()), 32'd0);
        if (glitchAt >= 0) begin
            repeat (8) @(negedge clk);
            checkVal("doneHold", 32'(done), 32'd1);
            checkVal("wrCntHold", 32'(writeCnt), 32'd11);
        end
    endtask

    task automatic fillRandom();
        for (int k = 0; k < 11; k++) rIn[k] = $urandom();
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        for (int k = 0; k < 11; k++) rIn[k] = 32'd0;
        repeat (3) @(negedge clk);
        checkVal("rstRdAddr", 32'(memReadAddr), 32'd0);
        checkVal("rstWrAddr", 32'(memWriteAddr), 32'd0);
        checkVal("rstMemIn", memIn, 32'd0);
        checkVal("rstWrite", 32'(memWrite), 32'd0);
        checkVal("rstDone", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // r[0] copied, saturated-magnitude inputs windowed.
        rIn[0] = 32'h12345678;
        for (int k = 1; k < 11; k++) rIn[k] = 32'h7FFFFFFF;
        runPass(-1);

        // Exact-power input on the last lag plus negative extremes.
        fillRandom();
        rIn[3]  = 32'h80000000;
        rIn[5]  = 32'hFFFFFFFF;
        rIn[10] = 32'h40000000;
        runPass(-1);

        // All-zero frame; done must hold until the next accepted start.
        for (int k = 0; k < 11; k++) rIn[k] = 32'd0;
        runPass(-1);
        repeat (20) @(negedge clk);
        checkVal("doneIdleHold", 32'(done), 32'd1);

        // Start pulses mid-pass and in FIN are ignored.
        fillRandom();
        runPass(10);
        fillRandom();
        runPass(44);

        // Reset mid-pass aborts; no further writes.
        fillRandom();
        pushExpected();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkVal("abortWrite", 32'(memWrite), 32'd0);
        checkVal("abortDone", 32'(done), 32'd0);
        checkVal("abortRdAddr", 32'(memReadAddr), 32'd0);
        expAddr.delete();
        expDat.delete();
        writeCnt = 0;
        repeat (60) @(negedge clk);
        checkVal("abortIdleWr", 32'(writeCnt), 32'd0);
        checkVal("abortIdleDone", 32'(done), 32'd0);

        // Fresh pass after abort.
        fillRandom();
        runPass(-1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
